// File: rtl/apple1_ps2_pkg.sv
// apple1_ps2_pkg: shared scancode constants, lookup result type and sender FSM states
package apple1_ps2_pkg;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;

  typedef struct packed {
    logic       ok;
    logic       shift;
    logic [7:0] code;
  } scan_t;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FRAME, S_GAP} state_t;

  // byte idx of the make/break sequence; shifted keys are wrapped in left-shift make/break
  function automatic logic [7:0] seq_byte(input logic shift, input logic [7:0] code,
                                          input logic [2:0] idx);
    return shift ? ((idx == 3'd0 || idx == 3'd5) ? SC_LSHIFT :
                    (idx == 3'd2 || idx == 3'd4) ? SC_BREAK : code)
                 : ((idx == 3'd1) ? SC_BREAK : code);
  endfunction

  // {stop, odd parity, data, start}, shifted out LSB first
  function automatic logic [10:0] frame_bits(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_ascii_to_scancode.sv
// ps2_ascii_to_scancode: US-layout ASCII to Set-2 make code plus shift flag
module ps2_ascii_to_scancode
  import apple1_ps2_pkg::*;
(
  input  logic [7:0] i_ascii,
  output scan_t      o_scan
);
  logic [7:0] w_key;
  logic [8:0] w_sc;
  logic       w_ok;
  assign w_key = (i_ascii >= "A" && i_ascii <= "Z") ? (i_ascii | 8'h20) : i_ascii;
  always_comb begin
    w_ok = 1'b1;
    w_sc = 9'h000;
    case (w_key)
      "a": w_sc = 9'h01C;  "b": w_sc = 9'h032;  "c": w_sc = 9'h021;  "d": w_sc = 9'h023;
      "e": w_sc = 9'h024;  "f": w_sc = 9'h02B;  "g": w_sc = 9'h034;  "h": w_sc = 9'h033;
      "i": w_sc = 9'h043;  "j": w_sc = 9'h03B;  "k": w_sc = 9'h042;  "l": w_sc = 9'h04B;
      "m": w_sc = 9'h03A;  "n": w_sc = 9'h031;  "o": w_sc = 9'h044;  "p": w_sc = 9'h04D;
      "q": w_sc = 9'h015;  "r": w_sc = 9'h02D;  "s": w_sc = 9'h01B;  "t": w_sc = 9'h02C;
      "u": w_sc = 9'h03C;  "v": w_sc = 9'h02A;  "w": w_sc = 9'h01D;  "x": w_sc = 9'h022;
      "y": w_sc = 9'h035;  "z": w_sc = 9'h01A;
      "0": w_sc = 9'h045;  "1": w_sc = 9'h016;  "2": w_sc = 9'h01E;  "3": w_sc = 9'h026;
      "4": w_sc = 9'h025;  "5": w_sc = 9'h02E;  "6": w_sc = 9'h036;  "7": w_sc = 9'h03D;
      "8": w_sc = 9'h03E;  "9": w_sc = 9'h046;
      ")": w_sc = 9'h145;  "!": w_sc = 9'h116;  "@": w_sc = 9'h11E;  "#": w_sc = 9'h126;
      "$": w_sc = 9'h125;  "%": w_sc = 9'h12E;  "^": w_sc = 9'h136;  "&": w_sc = 9'h13D;
      "*": w_sc = 9'h13E;  "(": w_sc = 9'h146;
      8'h60: w_sc = 9'h00E;  "~": w_sc = 9'h10E;
      "-": w_sc = 9'h04E;  "_": w_sc = 9'h14E;  "=": w_sc = 9'h055;  "+": w_sc = 9'h155;
      "[": w_sc = 9'h054;  "{": w_sc = 9'h154;  "]": w_sc = 9'h05B;  "}": w_sc = 9'h15B;
      8'h5C: w_sc = 9'h05D; "|": w_sc = 9'h15D;  ";": w_sc = 9'h04C;  ":": w_sc = 9'h14C;
      "'": w_sc = 9'h052;  8'h22: w_sc = 9'h152; ",": w_sc = 9'h041;  "<": w_sc = 9'h141;
      ".": w_sc = 9'h049;  ">": w_sc = 9'h149;  "/": w_sc = 9'h04A;  "?": w_sc = 9'h14A;
      " ": w_sc = 9'h029;
      8'h0D: w_sc = {1'b0, SC_ENTER};
      8'h08: w_sc = {1'b0, SC_BKSP};
      8'h1B: w_sc = {1'b0, SC_ESC};
      default: w_ok = 1'b0;
    endcase
  end
  assign o_scan = {w_ok, w_sc};
endmodule

// File: rtl/ps2_ascii_sender.sv
// ps2_ascii_sender: device-side PS/2 keyboard emulator turning ASCII into Set-2 make/break frames
module ps2_ascii_sender
  import apple1_ps2_pkg::*;
#(
  parameter int CLK_HALF_DIV = 500,
  parameter int GAP_CYCLES   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ascii_valid,
  input  logic [7:0] ascii_data,
  output logic       ascii_ready,
  output logic       ps2_clk,
  output logic       ps2_din,
  output logic       busy
);
  localparam int PW = (CLK_HALF_DIV > 1) ? $clog2(CLK_HALF_DIV) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_HALF_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        r_state;
  logic [7:0]    r_ascii;
  logic          r_shift;
  logic [7:0]    r_code;
  logic [2:0]    r_idx;
  logic [10:0]   r_sh;
  logic [PW-1:0] r_phase;
  logic          r_half;
  logic [3:0]    r_bit;
  logic [GW-1:0] r_gap;
  scan_t         w_scan;
  logic [2:0]    w_next_idx;
  logic          w_last_idx;

  ps2_ascii_to_scancode u_lookup (
    .i_ascii (r_ascii),
    .o_scan  (w_scan)
  );

  assign w_next_idx  = r_idx + 3'd1;
  assign w_last_idx  = r_idx == (r_shift ? 3'd5 : 3'd2);
  assign ascii_ready = (r_state == S_IDLE) && !reset;
  assign busy        = ~ascii_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ascii <= '0;
      r_shift <= 1'b0;
      r_code  <= '0;
      r_idx   <= '0;
      r_sh    <= '1;
      r_phase <= '0;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_gap   <= '0;
      ps2_clk <= 1'b1;
      ps2_din <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (ascii_valid) begin
          r_ascii <= ascii_data;
          r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          r_shift <= w_scan.shift;
          r_code  <= w_scan.code;
          r_idx   <= '0;
          r_phase <= '0;
          r_half  <= 1'b0;
          r_bit   <= '0;
          if (w_scan.ok) begin
            r_sh    <= frame_bits(seq_byte(w_scan.shift, w_scan.code, 3'd0));
            ps2_din <= 1'b0;
            r_state <= S_FRAME;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FRAME: begin
          if (r_phase != PH_LAST) begin
            r_phase <= r_phase + 1'b1;
          end else begin
            // high half ends with the falling edge; low half ends by starting the next bit
            r_phase <= '0;
            r_half  <= ~r_half;
            ps2_clk <= r_half;
            if (r_half && r_bit == 4'd10) begin
              ps2_din <= 1'b1;
              r_bit   <= '0;
              r_gap   <= '0;
              r_state <= S_GAP;
            end else if (r_half) begin
              r_bit   <= r_bit + 4'd1;
              r_sh    <= {1'b1, r_sh[10:1]};
              ps2_din <= r_sh[1];
            end
          end
        end
        S_GAP: begin
          if (r_gap != GAP_LAST) begin
            r_gap <= r_gap + 1'b1;
          end else if (w_last_idx) begin
            r_gap   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= w_next_idx;
            r_sh    <= frame_bits(seq_byte(r_shift, r_code, w_next_idx));
            ps2_din <= 1'b0;
            r_gap   <= '0;
            r_phase <= '0;
            r_half  <= 1'b0;
            r_bit   <= '0;
            r_state <= S_FRAME;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_ascii_sender.sv
// tb_ps2_ascii_sender: random and directed ASCII stimulus, frames decoded on ps2_clk falls and scoreboarded
module tb_ps2_ascii_sender;
  localparam int DIV  = 4;
  localparam int GAP  = 8;
  localparam int FCYC = 22 * DIV + GAP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ascii_valid = 1'b0;
  logic [7:0] ascii_data = 8'h00;
  logic       ascii_ready, ps2_clk, ps2_din, busy;

  int          tests = 0, fails = 0, n_fall = 0, nbits = 0;
  logic [10:0] fr;
  logic        pd = 1'b1;
  logic [7:0]  exp_q[$];

  string      unsh = "1234567890-=qwertyuiop[]|asdfghjkl;'zxcvbnm,./";
  string      shs  = "!@#$%^&*()_+QWERTYUIOP{}|ASDFGHJKL:|ZXCVBNM<>?";
  logic [7:0] cds[46] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                          8'h4E, 8'h55, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                          8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                          8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52, 8'h1A, 8'h22, 8'h21, 8'h2A,
                          8'h32, 8'h31, 8'h3A, 8'h41, 8'h49, 8'h4A};

  ps2_ascii_sender #(.CLK_HALF_DIV(DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .ascii_valid(ascii_valid), .ascii_data(ascii_data),
    .ascii_ready(ascii_ready), .ps2_clk(ps2_clk), .ps2_din(ps2_din), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void model(input logic [7:0] c, output bit ok, output bit sh,
                                output logic [7:0] code);
    ok = 0; sh = 0; code = 8'h00;
    for (int i = 0; i < 46; i++) begin
      if (unsh[i] == c) begin ok = 1; code = cds[i]; end
      if (shs[i] == c) begin ok = 1; sh = !(c >= 8'h41 && c <= 8'h5A); code = cds[i]; end
    end
    if (c == 8'h60) begin ok = 1; code = 8'h0E; end
    if (c == 8'h7E) begin ok = 1; sh = 1; code = 8'h0E; end
    if (c == 8'h20) begin ok = 1; code = 8'h29; end
    if (c == 8'h0D) begin ok = 1; code = 8'h5A; end
    if (c == 8'h08) begin ok = 1; code = 8'h66; end
    if (c == 8'h1B) begin ok = 1; code = 8'h76; end
  endfunction

  always @(negedge ps2_clk or posedge reset) begin
    if (reset) nbits = 0;
    else begin
      n_fall++;
      fr[nbits] = ps2_din;
      nbits++;
      if (nbits == 11) begin
        nbits = 0;
        check("start_bit", 32'(fr[0]), 0);
        check("stop_bit", 32'(fr[10]), 1);
        check("odd_parity", 32'(^fr[9:1]), 1);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_frame: got %0h, expected no frame", fr[8:1]);
        end else check("frame_byte", 32'(fr[8:1]), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (ps2_din !== pd) check("din_changes_with_clk_high", 32'(ps2_clk), 1);
    pd = ps2_din;
  end

  task automatic accept(input logic [7:0] c, output int waited, output int lat);
    bit ok, sh;
    logic [7:0] code;
    model(c, ok, sh, code);
    if (ok) begin
      if (sh) exp_q.push_back(8'h12);
      exp_q.push_back(code); exp_q.push_back(8'hF0); exp_q.push_back(code);
      if (sh) begin exp_q.push_back(8'hF0); exp_q.push_back(8'h12); end
    end
    lat = 1 + (ok ? (sh ? 6 : 3) : 0) * FCYC;
    ascii_valid = 1'b1;
    ascii_data  = c;
    waited = 0;
    while (!ascii_ready && waited < 2000) begin @(negedge clk); waited++; end
    if (!ascii_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int lat);
    int k = 0;
    while (!ascii_ready && k < 2000) begin @(negedge clk); k++; end
    check(name, k, lat);
  endtask

  initial begin
    int w, lat, f;
    logic [7:0] c;
    unsh.putc(24, 8'h5C);
    shs.putc(35, 8'h22);
    repeat (3) @(negedge clk);
    check("reset_ps2_clk", 32'(ps2_clk), 1);
    check("reset_ps2_din", 32'(ps2_din), 1);
    check("reset_ready", 32'(ascii_ready), 0);
    check("reset_busy", 32'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(ascii_ready), 1);

    accept(8'h41, w, lat); ascii_valid = 1'b0;
    wait_ready("A_latency", 1 + 3 * FCYC);
    accept(8'h21, w, lat); ascii_valid = 1'b0;
    wait_ready("bang_latency", 1 + 6 * FCYC);
    accept(8'h0D, w, lat); ascii_valid = 1'b0;
    wait_ready("cr_latency", lat);
    f = n_fall;
    accept(8'h80, w, lat); ascii_valid = 1'b0;
    wait_ready("unmapped_latency", 1);
    repeat (20) @(negedge clk);
    check("unmapped_no_edges", n_fall, f);

    accept(8'h48, w, lat);
    accept(8'h49, w, lat);
    check("held_valid_wait", w, 1 + 3 * FCYC);
    ascii_valid = 1'b0;
    wait_ready("I_latency", lat);

    repeat (14) begin
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
      accept(c, w, lat); ascii_valid = 1'b0;
      wait_ready("random_latency", lat);
    end

    accept(8'h41, w, lat); ascii_valid = 1'b0;
    repeat (35) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_clk", 32'(ps2_clk), 1);
    check("midframe_reset_din", 32'(ps2_din), 1);
    check("midframe_reset_ready", 32'(ascii_ready), 0);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_midframe_reset", 32'(ascii_ready), 1);
    f = n_fall;
    repeat (300) @(negedge clk);
    check("no_edges_after_reset", n_fall, f);

    reset = 1'b1; ascii_valid = 1'b1; ascii_data = 8'h41;
    @(negedge clk);
    reset = 1'b0; ascii_valid = 1'b0;
    f = n_fall;
    repeat (2) @(negedge clk);
    check("reset_wins_ready", 32'(ascii_ready), 1);
    repeat (300) @(negedge clk);
    check("reset_wins_no_edges", n_fall, f);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
